// File: rtl/alu_in_responder.sv
// ALU_in protocol responder: accepts op/a/b on valid&ready,
// executes with op-dependent latency, pulses done with a held result.
module alu_in_responder #(
  parameter int ALU_IN_OP_WIDTH      = 8,
  parameter int ALU_OUT_RESULT_WIDTH = 16,
  parameter int MUL_LATENCY          = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_rst,
  input  logic                            valid,
  input  logic [2:0]                      op,
  input  logic [ALU_IN_OP_WIDTH-1:0]      a,
  input  logic [ALU_IN_OP_WIDTH-1:0]      b,
  output logic                            ready,
  output logic                            done,
  output logic [ALU_OUT_RESULT_WIDTH-1:0] result
);

  localparam int W  = ALU_IN_OP_WIDTH;
  localparam int RW = ALU_OUT_RESULT_WIDTH;
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic {
    IDLE,
    EXEC
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [RW-1:0]  result_q, result_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [RW-1:0]  f_res;
  logic           rst_term;
  logic           accept;
  logic           skip_op;

  assign rst_term = rst | ~alu_rst;
  assign accept   = (state_q == IDLE) & ready_q & valid;
  assign skip_op  = (op == OP_NOP) | (op == OP_RST);

  always_comb begin
    f_res = '0;
    case (op_q)
      OP_ADD:  f_res = RW'(a_q) + RW'(b_q);
      OP_AND:  f_res = RW'(a_q & b_q);
      OP_XOR:  f_res = RW'(a_q ^ b_q);
      OP_MUL:  f_res = RW'(a_q) * RW'(b_q);
      default: f_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    result_d = result_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept && !skip_op) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = (op == OP_MUL) ? CW'(MUL_LATENCY - 1) : '0;
          state_d = EXEC;
          ready_d = 1'b0;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = f_res;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_term) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_in_responder.sv
// Directed bench for alu_in_responder with a result scoreboard
// popped by a done monitor.
module tb_alu_in_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_rst;
  logic        valid;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  alu_in_responder #(
    .ALU_IN_OP_WIDTH(8),
    .ALU_OUT_RESULT_WIDTH(16),
    .MUL_LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_rst(alu_rst),
    .valid(valid),
    .op(op),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [7:0] aa, input logic [7:0] bb);
    valid = v;
    op    = o;
    a     = aa;
    b     = bb;
  endtask

  // Every done must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        chk("sb_result", result, sb.pop_front());
      end
    end
  end

  initial begin
    rst     = 1'b1;
    alu_rst = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);

    // reset and ready release
    repeat (3) step();
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    rst = 1'b0;
    chk("ready_before_edge", 16'(ready), 16'd0);
    step();
    chk("ready_after_rst", 16'(ready), 16'd1);

    // add with carry
    drive(1'b1, 3'b001, 8'hFF, 8'h01);
    sb.push_back(16'h0100);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("add_ready_low", 16'(ready), 16'd0);
    chk("add_done_low", 16'(done), 16'd0);
    step();
    chk("add_done", 16'(done), 16'd1);
    chk("add_ready", 16'(ready), 16'd1);
    chk("add_result", result, 16'h0100);
    step();
    chk("add_done_drop", 16'(done), 16'd0);

    // mul with valid held during EXEC
    drive(1'b1, 3'b100, 8'hFF, 8'hFF);
    sb.push_back(16'hFE01);
    step();
    drive(1'b1, 3'b001, 8'h11, 8'h11);
    for (int i = 0; i < 4; i++) begin
      chk("mul_ready_low", 16'(ready), 16'd0);
      chk("mul_done_low", 16'(done), 16'd0);
      step();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("mul_done", 16'(done), 16'd1);
    chk("mul_ready", 16'(ready), 16'd1);
    chk("mul_result", result, 16'hFE01);
    step();
    chk("mul_done_drop", 16'(done), 16'd0);
    chk("mul_hold", result, 16'hFE01);

    // and, then xor issued in the done cycle
    drive(1'b1, 3'b010, 8'hF0, 8'h3C);
    sb.push_back(16'h0030);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    step();
    chk("and_done", 16'(done), 16'd1);
    chk("and_result", result, 16'h0030);
    drive(1'b1, 3'b011, 8'hF0, 8'h3C);
    sb.push_back(16'h00CC);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("b2b_done_gap", 16'(done), 16'd0);
    chk("b2b_ready_low", 16'(ready), 16'd0);
    step();
    chk("xor_done", 16'(done), 16'd1);
    chk("xor_result", result, 16'h00CC);
    step();

    // soft reset aborts an in-flight mul
    drive(1'b1, 3'b100, 8'h10, 8'h10);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    step();
    step();
    alu_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_ready", 16'(ready), 16'd0);
      chk("abort_done", 16'(done), 16'd0);
      chk("abort_result", result, 16'h0000);
    end
    alu_rst = 1'b1;
    step();
    chk("abort_ready_back", 16'(ready), 16'd1);
    chk("abort_no_done", 16'(done), 16'd0);

    // consumed no-work ops
    drive(1'b1, 3'b000, 8'h12, 8'h34);
    step();
    chk("nop_done", 16'(done), 16'd0);
    chk("nop_ready", 16'(ready), 16'd1);
    drive(1'b1, 3'b111, 8'h12, 8'h34);
    step();
    chk("rstop_done", 16'(done), 16'd0);
    chk("rstop_ready", 16'(ready), 16'd1);

    // xor to make result nonzero, then reserved clears it
    drive(1'b1, 3'b011, 8'h05, 8'h07);
    sb.push_back(16'h0002);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    step();
    chk("xor2_result", result, 16'h0002);
    drive(1'b1, 3'b101, 8'h05, 8'h07);
    sb.push_back(16'h0000);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("rsv_ready_low", 16'(ready), 16'd0);
    step();
    chk("rsv_done", 16'(done), 16'd1);
    chk("rsv_result", result, 16'h0000);
    step();
    chk("rsv_done_drop", 16'(done), 16'd0);

    // simultaneous resets
    rst     = 1'b1;
    alu_rst = 1'b0;
    step();
    chk("dual_rst_ready", 16'(ready), 16'd0);
    rst     = 1'b0;
    alu_rst = 1'b1;
    step();
    chk("dual_rst_release", 16'(ready), 16'd1);

    step();
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_in_responder.md
Name: alu_in_responder

Overview:
Synthesizable responder for the ALU_in protocol. It sits at the far end of the ALU_in interface, where the ALU_in driver BFM acts as initiator. It accepts valid/op/a/b transfers when ready is high, executes the operation with op-dependent multi-cycle latency, and presents a one-cycle done pulse with a held result. It is the RTL counterpart the ALU_in agent drives, and it serves as the DUT core for ALU_in/ALU_out benches.

Parameters:
ALU_IN_OP_WIDTH, 8, operand width W of a and b
ALU_OUT_RESULT_WIDTH, 16, result width; must equal 2*ALU_IN_OP_WIDTH
MUL_LATENCY, 4, cycles from acceptance to done for mul_op; must be >= 1

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
alu_rst  input  1  protocol soft reset, active-low, sampled synchronously on clk
valid  input  1  initiator transfer request
op  input  3  opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 101/110 reserved, 111 rst_op
a  input  W  operand A
b  input  W  operand B
ready  output  1  responder can accept a transfer this cycle
done  output  1  one-cycle pulse; result valid
result  output  2W  last completed result, held until the next done

Behaviour:
- Reset term: rst==1 OR alu_rst==0, sampled at posedge. Either one forces state=IDLE, ready=0, done=0, result=0 and cnt=0.
- Ready after reset: at the first edge with reset inactive, ready<=1. Ready rises one cycle after reset release.
- States:
  - IDLE: ready=1.
  - EXEC: ready=0, down-counter cnt active.
- Acceptance: occurs at a posedge where state==IDLE, ready==1 and valid==1.
- At the acceptance edge:
  - Capture op/a/b into internal registers.
  - Op latency L: 1 for add/and/xor/reserved, MUL_LATENCY for mul.
  - cnt <= L-1, state <= EXEC, ready <= 0.
  - no_op and rst_op (111) are consumed without starting work: state stays IDLE, ready stays 1, no done.
- In EXEC at each edge:
  - If cnt==0: result <= f(captured op,a,b), done <= 1, ready <= 1, state <= IDLE.
  - Otherwise: cnt <= cnt-1.
- Latency: with acceptance at edge T, done=1 and ready=1 after edge T+L. ready is low for exactly L cycles.
- done timing: done deasserts at the next edge unless a new completion occurs (back-to-back is impossible because L>=1).
- Back-to-back: done and ready are high in the same cycle. A valid in that cycle is accepted at the following edge.
- valid while ready==0: ignored. No capture, no error. op/a/b are don't-care (may be Z/X) whenever valid==0 or ready==0.
- Arithmetic (zero-extended to 2W):
  - add: a+b, carry lands in bit W.
  - and: a&b.
  - xor: a^b.
  - mul: full unsigned a*b, computed from the captured operands; the counter models latency.
  - reserved 101/110: result=0, done still pulses.
- Reset mid-EXEC: operation aborted, no done, result cleared to 0. ready returns one cycle after reset release.
- rst and alu_rst asserted simultaneously: identical to either alone.
- Reset coinciding with the completion edge: reset wins; done stays 0.

Test Plan:
1. rst=1 for 3 cycles, alu_rst=1 -> ready=0, done=0, result=0x0000. One edge after rst drops, ready=1.
2. add a=0xFF b=0x01 accepted at edge T -> ready=0 for 1 cycle; at T+1 done=1, result=0x0100, ready=1. done=0 at T+2.
3. mul a=0xFF b=0xFF -> ready low 4 cycles; done at T+4, result=0xFE01. valid held high with a=0x11 during EXEC is ignored; result is not corrupted.
4. and 0xF0,0x3C, then xor 0xF0,0x3C issued in the done/ready cycle -> results 0x0030 then 0x00CC. The two dones are 2 cycles apart.
5. mul 0x10*0x10 accepted, alu_rst=0 for 10 cycles starting 2 cycles later -> no done, result=0x0000, ready=0 throughout. ready=1 one edge after alu_rst=1.
6. valid with op=000 and op=111 -> no done, ready stays 1. op=101 a=0x05 b=0x07 -> done after 1 cycle, result=0x0000.
